// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit: load-use stall, branch flush and EX operand forwarding
// selection for an in-order MIPS pipeline.
//
// Ports:
//   clock, resetN             rising-edge clock, async active-low reset
//   idRs/idRt, idUsesRs/Rt    ID-stage source registers and their use flags
//   idWrite, idDst, idIsLoad  ID-stage destination info
//   branchTaken               EX instruction redirects the PC this cycle
//   stall, flushId            combinational pipeline control
//   fwdA, fwdB                registered EX operand source (0 = regfile,
//                             k = stage k after EX)
// Optional: define MIPS_HAZARD_MULDIV_EN to add mdStart, idUsesHiLo,
// mdBusy and the MD_LAT parameter (multi-cycle mul/div busy tracking).

module mips_hazard_unit #(
    parameter int REG_W = 5,
    parameter int DEPTH = 3
`ifdef MIPS_HAZARD_MULDIV_EN
    ,
    parameter int MD_LAT = 32
`endif
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             idUsesRs,
    input  logic             idUsesRt,
    input  logic             idWrite,
    input  logic [REG_W-1:0] idDst,
    input  logic             idIsLoad,
    input  logic             branchTaken,
`ifdef MIPS_HAZARD_MULDIV_EN
    input  logic             mdStart,
    input  logic             idUsesHiLo,
    output logic             mdBusy,
`endif
    output logic             stall,
    output logic             flushId,
    output logic [2:0]       fwdA,
    output logic [2:0]       fwdB
);

    // Scoreboard: entry 0 is EX, entry DEPTH-1 the oldest tracked stage.
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] ld_q, ld_d;
    logic [REG_W-1:0] dst_q [DEPTH];
    logic [REG_W-1:0] dst_d [DEPTH];

    logic [2:0] fwd_a_q, fwd_a_d;
    logic [2:0] fwd_b_q, fwd_b_d;

    // Only entries 0..DEPTH-2 can forward; the oldest stage writes the
    // register file before it is read.
    logic [DEPTH-2:0] hit_rs, hit_rt;
    logic             load_use;
    logic             md_hazard;

    // The oldest entry is only shifted out, never inspected.
    logic unused_oldest;
    assign unused_oldest = ^{vld_q[DEPTH-1], ld_q[DEPTH-1], dst_q[DEPTH-1]};

    always_comb begin
        hit_rs = '0;
        hit_rt = '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            hit_rs[i] = idUsesRs && vld_q[i] && (dst_q[i] == idRs) && (|idRs);
            hit_rt[i] = idUsesRt && vld_q[i] && (dst_q[i] == idRt) && (|idRt);
        end
    end

    assign load_use = ld_q[0] && (hit_rs[0] || hit_rt[0]);

`ifdef MIPS_HAZARD_MULDIV_EN
    localparam int MD_W = $clog2(MD_LAT + 1);

    logic [MD_W-1:0] md_cnt_q, md_cnt_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (|md_cnt_q) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end else if (mdStart) begin
            md_cnt_d = MD_W'(MD_LAT);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign mdBusy    = |md_cnt_q;
    assign md_hazard = mdBusy && idUsesHiLo;
`else
    assign md_hazard = 1'b0;
`endif

    // Flush wins over stall; both are held low during reset.
    assign flushId = resetN && branchTaken;
    assign stall   = resetN && !flushId && (load_use || md_hazard);

    always_comb begin
        vld_d    = '0;
        ld_d     = '0;
        dst_d[0] = idDst;
        vld_d[0] = idWrite && !stall && !flushId;
        ld_d[0]  = idIsLoad;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            ld_d[i]  = ld_q[i-1];
            dst_d[i] = dst_q[i-1];
        end
    end

    // Walk from oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_a_d = '0;
        fwd_b_d = '0;
        if (!stall && !flushId) begin
            for (int i = DEPTH - 2; i >= 0; i--) begin
                if (hit_rs[i]) fwd_a_d = 3'(i + 1);
                if (hit_rt[i]) fwd_b_d = 3'(i + 1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            vld_q   <= '0;
            ld_q    <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            ld_q    <= ld_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i] <= dst_d[i];
            end
        end
    end

    assign fwdA = fwd_a_q;
    assign fwdB = fwd_b_q;

endmodule

// File: tb/tb_mips_hazard_unit.sv
// tb_mips_hazard_unit: directed vectors with a scoreboard queue and an
// independent monitor for mips_hazard_unit (DEPTH=4).

module tb_mips_hazard_unit;

    localparam int REG_W = 5;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             resetN = 1'b0;
    logic [REG_W-1:0] idRs = '0, idRt = '0, idDst = '0;
    logic             idUsesRs = 1'b0, idUsesRt = 1'b0;
    logic             idWrite = 1'b0, idIsLoad = 1'b0, branchTaken = 1'b0;
    logic             stall, flushId;
    logic [2:0]       fwdA, fwdB;
`ifdef MIPS_HAZARD_MULDIV_EN
    logic             mdStart = 1'b0, idUsesHiLo = 1'b0, mdBusy;
`endif

    always #5 clock = ~clock;

    mips_hazard_unit #(
        .REG_W(REG_W),
        .DEPTH(DEPTH)
`ifdef MIPS_HAZARD_MULDIV_EN
        ,
        .MD_LAT(4)
`endif
    ) dut (
        .clock(clock),
        .resetN(resetN),
        .idRs(idRs),
        .idRt(idRt),
        .idUsesRs(idUsesRs),
        .idUsesRt(idUsesRt),
        .idWrite(idWrite),
        .idDst(idDst),
        .idIsLoad(idIsLoad),
        .branchTaken(branchTaken),
`ifdef MIPS_HAZARD_MULDIV_EN
        .mdStart(mdStart),
        .idUsesHiLo(idUsesHiLo),
        .mdBusy(mdBusy),
`endif
        .stall(stall),
        .flushId(flushId),
        .fwdA(fwdA),
        .fwdB(fwdB)
    );

    typedef struct {
        int         id;
        logic       stall;
        logic       flush;
        logic [2:0] fa;
        logic [2:0] fb;
        logic       busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n = 0;

    logic stage_md_start = 1'b0;
    logic stage_uhl = 1'b0;
    logic stage_busy = 1'b0;

    task automatic chk(input string nm, input int id,
                       input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", nm, id, act, exp);
        end
    endtask

    // Inputs change on the falling edge; the expected response for that
    // cycle (comb outputs plus the currently registered fwd values) is queued.
    task automatic step(input logic rst,
                        input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic wr, input logic [4:0] dst,
                        input logic ld, input logic br,
                        input logic es, input logic ef,
                        input logic [2:0] efa, input logic [2:0] efb);
        exp_t e;
        @(negedge clock);
        resetN      = rst;
        idRs        = rs;
        idUsesRs    = urs;
        idRt        = rt;
        idUsesRt    = urt;
        idWrite     = wr;
        idDst       = dst;
        idIsLoad    = ld;
        branchTaken = br;
`ifdef MIPS_HAZARD_MULDIV_EN
        mdStart     = stage_md_start;
        idUsesHiLo  = stage_uhl;
`endif
        e = '{n, es, ef, efa, efb, stage_busy};
        sb.push_back(e);
        n++;
    endtask

    task automatic nop(input logic [2:0] efa, input logic [2:0] efb);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, efa, efb);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stall", e.id, {2'b0, stall}, {2'b0, e.stall});
                chk("flushId", e.id, {2'b0, flushId}, {2'b0, e.flush});
                chk("fwdA", e.id, fwdA, e.fa);
                chk("fwdB", e.id, fwdB, e.fb);
`ifdef MIPS_HAZARD_MULDIV_EN
                chk("mdBusy", e.id, {2'b0, mdBusy}, {2'b0, e.busy});
`endif
            end
        end
    end

    initial begin : driver
        int waited;
        // reset held with hazardous inputs: all outputs low
        step(0, 5, 1, 5, 1, 1, 5, 1, 1, 0, 0, 0, 0);
        // add r3; read r3 -> fwdA=1
        step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(1, 0);
        // lw r4; read r4 in rt -> one stall, then fwdB=2
        step(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 2);
        // load to r0, read r0 -> nothing
        step(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
        // lw r6; load-use with branch -> flush, no stall, entry0 empty
        step(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0);
        step(1, 6, 1, 0, 0, 1, 7, 1, 1, 0, 1, 0, 0);
        step(1, 7, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 2);
        // r9 written, read 3 stages later -> 3, 4 stages later -> 0
        step(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
        nop(0, 0);
        step(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 3, 0);
        // two writers of r10: youngest wins; unused rt not forwarded
        step(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0);
        step(1, 10, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(1, 0);
        // reset in the middle of a load-use stall
        step(1, 0, 0, 0, 0, 1, 11, 1, 0, 0, 0, 0, 0);
        step(1, 11, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 11, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0);
`ifdef MIPS_HAZARD_MULDIV_EN
        stage_md_start = 1;
        nop(0, 0);
        stage_md_start = 0;
        stage_uhl = 1;
        stage_busy = 1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        stage_md_start = 1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        stage_md_start = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        stage_busy = 0;
        nop(0, 0);
        stage_uhl = 0;
        stage_md_start = 1;
        nop(0, 0);
        stage_md_start = 0;
        stage_uhl = 1;
        stage_busy = 1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        stage_busy = 0;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stage_uhl = 0;
        nop(0, 0);
`endif
        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clock);
            waited++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d pending, expected 0", sb.size());
        end
        @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_hazard_unit.md
MIPS_HAZARD_UNIT -- requirements
Module: mips_hazard_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter REG_W, default 5, SHALL set the register-address width.
REQ-003 Parameter DEPTH, default 3, range 2..7, SHALL set the number of in-flight stages tracked after ID (EX, MEM, WB, ...).
REQ-004 clock  input  1  rising-edge clock.
REQ-005 resetN  input  1  asynchronous active-low reset.
REQ-006 idRs  input  REG_W  source register A of the ID-stage instruction.
REQ-007 idRt  input  REG_W  source register B of the ID-stage instruction.
REQ-008 idUsesRs  input  1  ID instruction reads idRs.
REQ-009 idUsesRt  input  1  ID instruction reads idRt.
REQ-010 idWrite  input  1  ID instruction writes a register; low means no instruction or no write.
REQ-011 idDst  input  REG_W  destination register of the ID instruction.
REQ-012 idIsLoad  input  1  ID instruction is a load (result available at end of MEM).
REQ-013 branchTaken  input  1  the instruction in EX redirects the PC this cycle.
REQ-014 stall  output  1  combinational; hold PC and IF/ID, insert a bubble into EX.
REQ-015 flushId  output  1  combinational; squash the IF/ID instruction.
REQ-016 fwdA  output  3  registered; operand-A source for the EX instruction: 0 = register file, k = stage k (1 = MEM, 2 = WB, ...).
REQ-017 fwdB  output  3  registered; operand-B source, encoded as fwdA.

Function
REQ-018 The block SHALL hold a scoreboard entry[0..DEPTH-1] of {valid, dst, isLoad}; entry[0] is EX and entry[DEPTH-1] is the oldest stage.
REQ-019 Each clock SHALL shift entry[i] into entry[i+1]; entry[DEPTH-1] is discarded.
REQ-020 entry[0] SHALL load {idWrite, idDst, idIsLoad} when stall=0 and flushId=0, else it SHALL load valid=0.
REQ-021 A source SHALL match entry[i] only when valid=1, dst equals the source, and dst is nonzero; register 0 never matches.
REQ-022 stall SHALL be 1 when entry[0] is a valid load matching a used source (idUsesRs/idUsesRt); this stall lasts exactly one cycle.
REQ-023 fwdA SHALL be registered on each clock with stall=0 as the smallest i+1 over entry[0..DEPTH-2] matching idRs with idUsesRs=1, else 0; fwdB does the same for idRt/idUsesRt.
REQ-024 When stall=1 or flushId=1, fwdA and fwdB SHALL be registered as 0 (bubble).
REQ-025 flushId SHALL equal branchTaken; flush SHALL take priority over stall, and stall SHALL be forced to 0 while flushId=1.
REQ-026 A match against entry[DEPTH-1] SHALL NOT forward; the register file is written-before-read in that stage.

Reset
REQ-027 While resetN=0 all entries SHALL be invalid, fwdA=fwdB=0, and stall and flushId SHALL be 0 regardless of inputs.
REQ-028 After reset deasserts, the first clock edge SHALL capture ID normally; any reset mid-stall SHALL drop the pending stall.

Configuration
REQ-029 With MIPS_HAZARD_MULDIV_EN defined, the block SHALL add inputs mdStart and idUsesHiLo (1 bit each), output mdBusy (1 bit), and parameter MD_LAT (default 32).
REQ-030 With the macro, mdStart while mdBusy=0 SHALL set a down-counter to MD_LAT and mdBusy stays 1 for exactly MD_LAT cycles; mdStart while busy is ignored; stall is also 1 while mdBusy=1 and idUsesHiLo=1; reset clears the counter and mdBusy.
REQ-031 Without the macro, those ports, the parameter and the counter SHALL be absent, and stall depends only on REQ-022.

Verification
REQ-032 add r3<-r1,r2 issued, then ID reads r3 with idUsesRs=1 -> no stall; fwdA=1 on the next cycle.
REQ-033 lw r4 issued, then ID reads r4 in rt -> stall=1 for one cycle, bubble in entry[0], then fwdB=2 when it issues.
REQ-034 Write to r0 followed by a read of r0 -> stall=0, fwdA=0.
REQ-035 branchTaken=1 in the same cycle as a load-use hazard -> flushId=1, stall=0, entry[0] invalid.
REQ-036 DEPTH=4: writer is 3 stages older than reader -> fwd=3; writer is 4 stages older -> fwd=0.
REQ-037 MULDIV_EN, MD_LAT=4: mdStart, then an mfhi in ID -> stall=1 for 4 cycles; resetN pulse at cycle 2 -> mdBusy=0 immediately.
